// File: rtl/fetch_queue.sv
// Instruction fetch queue.
// Issues word-aligned fetch requests to instruction memory, collects the
// in-order responses into a small FIFO and presents the head entry to decode.
// A redirect flushes the FIFO, restarts fetch at the new address and marks
// every response still in flight as stale so it is dropped when it returns.

module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    // Pointer width for the FIFO and count width able to hold 0..DEPTH.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic [CW:0]   in_flight;
    logic [31:0]   redirect_base;
    logic          grant;
    logic          resp_fire;
    logic          resp_stale;
    logic          push;
    logic          pop;

    // The low address bits of a redirect target are meaningless for a
    // word-aligned fetch; they are read here only so they are not dangling.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign redirect_base = {redirect_pc[31:2], 2'b00};

    // Entries already queued plus words still owed by memory; capping the
    // sum at DEPTH guarantees every response finds a free slot.
    assign in_flight = {1'b0, occupancy} + {1'b0, outstanding};

    // Gated by rst_n directly so requests stop the instant reset asserts and
    // start in the very first cycle after it releases.
    assign imem_req  = rst_n && !redirect_valid && (in_flight < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol violation and is
    // ignored entirely.
    assign resp_fire  = imem_rvalid && (outstanding != '0);
    assign resp_stale = resp_fire && (discard != '0);

    // A redirect wins over any push or pop in the same cycle.
    assign push = resp_fire && !resp_stale && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = (occupancy != '0);
    assign inst_out   = inst_mem[head];
    assign inst_pc    = pc_mem[head];

    // Request side: next fetch address and count of responses still owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
        end else if (redirect_valid) begin
            // No grant is possible while redirecting, only a returning word.
            fetch_pc    <= redirect_base;
            outstanding <= outstanding - CW'(resp_fire);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(grant) - CW'(resp_fire);
        end
    end

    // Response side: address tagging of kept words and stale-word dropping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_pc <= RESET_PC;
            discard <= '0;
        end else if (redirect_valid) begin
            // Everything still owed after this cycle belongs to the old stream.
            resp_pc <= redirect_base;
            discard <= outstanding - CW'(resp_fire);
        end else begin
            if (resp_stale) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    // FIFO bookkeeping: head/tail pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (redirect_valid) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage: instruction word and its address written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= imem_rdata;
            pc_mem[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by a randomized run,
// all checked every cycle against a queue-based model of the fetch rules.

module tb_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the fetch unit
    logic [31:0] m_fetch, m_resp;
    int          m_out, m_disc;
    logic [31:0] mq_inst[$];
    logic [31:0] mq_pc[$];

    // Memory side: addresses granted but not yet answered, in order
    logic [31:0] pend[$];

    // Stimulus knobs (percent)
    int unsigned gnt_pct, rv_pct, rdy_pct, spur_pct, redir_pct;
    logic [31:0] key;

    // Delivered-instruction log
    logic [31:0] del_pc[$];
    logic [31:0] del_inst[$];
    int cyc, first_grant, first_valid;
    logic [31:0] hold_pc;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch = RESET_PC;
        m_resp  = RESET_PC;
        m_out   = 0;
        m_disc  = 0;
        mq_inst.delete();
        mq_pc.delete();
        pend.delete();
    endtask

    task automatic clear_log();
        del_pc.delete();
        del_inst.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance.
    task automatic step();
        logic        e_req, s_dut_grant, s_rv, s_rdy, s_redir, s_gnt;
        logic [31:0] s_addr, s_rdata, s_rpc;
        int          rv_m;
        int          grant_m;
        if (redir_pct > 0) begin
            redirect_valid = ($urandom_range(99) < redir_pct);
            redirect_pc    = $urandom;
        end
        imem_gnt   = ($urandom_range(99) < gnt_pct);
        inst_ready = ($urandom_range(99) < rdy_pct);
        if (pend.size() > 0) begin
            imem_rvalid = ($urandom_range(99) < rv_pct);
            imem_rdata  = pend[0] ^ key;
        end else begin
            imem_rvalid = ($urandom_range(99) < spur_pct);
            imem_rdata  = $urandom;
        end
        #1;
        e_req = rst_n && !redirect_valid && (mq_pc.size() + m_out < DEPTH);
        chk1("imem_req", imem_req, e_req);
        chk32("imem_addr", imem_addr, m_fetch);
        chk1("inst_valid", inst_valid, mq_pc.size() > 0);
        if (mq_pc.size() > 0) begin
            chk32("inst_pc", inst_pc, mq_pc[0]);
            chk32("inst_out", inst_out, mq_inst[0]);
        end
        if (imem_req && imem_gnt && first_grant < 0) first_grant = cyc;
        if (inst_valid && first_valid < 0) first_valid = cyc;
        if (inst_valid && inst_ready) begin
            del_pc.push_back(inst_pc);
            del_inst.push_back(inst_out);
        end
        s_dut_grant = imem_req && imem_gnt;
        s_addr  = imem_addr;
        s_rv    = imem_rvalid;
        s_rdata = imem_rdata;
        s_rdy   = inst_ready;
        s_redir = redirect_valid;
        s_rpc   = redirect_pc;
        s_gnt   = imem_gnt;
        @(posedge clk);
        if (rst_n) begin
            // memory
            if (s_rv && pend.size() > 0) void'(pend.pop_front());
            if (s_dut_grant) pend.push_back(s_addr);
            // model
            rv_m    = (s_rv && m_out > 0) ? 1 : 0;
            grant_m = (e_req && s_gnt) ? 1 : 0;
            if (s_redir) begin
                mq_inst.delete();
                mq_pc.delete();
                m_fetch = {s_rpc[31:2], 2'b00};
                m_resp  = {s_rpc[31:2], 2'b00};
                m_out   = m_out - rv_m;
                m_disc  = m_out;
            end else begin
                if (mq_pc.size() > 0 && s_rdy) begin
                    void'(mq_pc.pop_front());
                    void'(mq_inst.pop_front());
                end
                if (rv_m == 1) begin
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        mq_inst.push_back(s_rdata);
                        mq_pc.push_back(m_resp);
                        m_resp = m_resp + 32'd4;
                    end
                end
                m_out = m_out + grant_m - rv_m;
                if (grant_m == 1) m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_rates(input int unsigned g, input int unsigned r, input int unsigned d);
        gnt_pct = g;
        rv_pct  = r;
        rdy_pct = d;
    endtask

    // Asynchronous reset pulse starting at a falling edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk1("arst_req", imem_req, 1'b0);
        chk1("arst_valid", inst_valid, 1'b0);
        chk32("arst_outstanding", 32'(dut.outstanding), 32'd0);
        chk32("arst_fetch_pc", 32'(dut.fetch_pc), RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        key = '0;
        spur_pct = 0;
        redir_pct = 0;
        set_rates(50, 50, 50);
        model_reset();
        first_grant = -1;
        first_valid = -1;
        cyc = 0;
        @(negedge clk);
        run(3);

        // Reset release, full-rate fetch, data equals address
        rst_n = 1'b1;
        set_rates(100, 100, 100);
        #1;
        chk1("rel_req", imem_req, 1'b1);
        chk32("rel_addr", imem_addr, RESET_PC);
        chk1("rel_valid", inst_valid, 1'b0);
        cyc = 0;
        first_grant = -1;
        first_valid = -1;
        clear_log();
        run(8);
        chk32("first_latency", 32'(first_valid - first_grant), 32'd2);
        if (del_pc.size() >= 3) begin
            chk32("seq_pc0", del_pc[0], 32'h0);
            chk32("seq_pc1", del_pc[1], 32'h4);
            chk32("seq_pc2", del_pc[2], 32'h8);
            chk32("seq_inst2", del_inst[2], 32'h8);
        end else begin
            chk32("seq_count", 32'(del_pc.size()), 32'd3);
        end

        // Backpressure for 10 cycles
        set_rates(100, 100, 0);
        step();
        hold_pc = (mq_pc.size() > 0) ? mq_pc[0] : 32'hDEAD_BEEF;
        run(9);
        #1;
        chk1("bp_req_drop", imem_req, 1'b0);
        chk1("bp_valid", inst_valid, 1'b1);
        chk32("bp_hold", inst_pc, hold_pc);
        set_rates(100, 100, 100);
        run(10);
        for (int i = 1; i < del_pc.size(); i++) begin
            chk32("stream_pc", del_pc[i], del_pc[i-1] + 32'd4);
            chk32("stream_inst", del_inst[i], del_pc[i]);
        end

        // Redirect with two responses outstanding
        set_rates(0, 100, 100);
        run(6);
        #1;
        chk1("drain_valid", inst_valid, 1'b0);
        chk1("drain_req", imem_req, 1'b1);
        set_rates(100, 0, 100);
        run(2);
        #1;
        chk1("two_out_req", imem_req, 1'b0);
        redirect_to(32'h0000_0103);
        #1;
        chk32("redir_discard", 32'(dut.discard), 32'd2);
        clear_log();
        set_rates(100, 100, 100);
        run(12);
        if (del_pc.size() >= 2) begin
            chk32("redir_pc0", del_pc[0], 32'h0000_0100);
            chk32("redir_inst0", del_inst[0], 32'h0000_0100);
            chk32("redir_pc1", del_pc[1], 32'h0000_0104);
        end else begin
            chk32("redir_count", 32'(del_pc.size()), 32'd2);
        end

        // Redirect coinciding with a pop and an arriving response
        set_rates(0, 100, 100);
        run(6);
        set_rates(100, 0, 0);
        step();
        set_rates(100, 100, 0);
        step();
        #1;
        chk1("pre_valid", inst_valid, 1'b1);
        chk32("pre_outstanding", 32'(dut.outstanding), 32'd1);
        set_rates(100, 100, 100);
        redirect_to(32'h0000_0200);
        #1;
        chk1("coll_valid", inst_valid, 1'b0);
        chk32("coll_discard", 32'(dut.discard), 32'd0);
        clear_log();
        run(10);
        if (del_pc.size() >= 1) chk32("coll_next_pc", del_pc[0], 32'h0000_0200);
        else chk32("coll_count", 32'(del_pc.size()), 32'd1);

        // Address wrap
        redirect_to(32'hFFFF_FFF8);
        clear_log();
        run(12);
        if (del_pc.size() >= 3) begin
            chk32("wrap_pc0", del_pc[0], 32'hFFFF_FFF8);
            chk32("wrap_pc1", del_pc[1], 32'hFFFF_FFFC);
            chk32("wrap_pc2", del_pc[2], 32'h0000_0000);
        end else begin
            chk32("wrap_count", 32'(del_pc.size()), 32'd3);
        end

        // Reset mid-stream with two outstanding, then unmatched responses
        set_rates(0, 100, 100);
        run(6);
        set_rates(100, 0, 100);
        run(2);
        #1;
        chk32("mid_outstanding", 32'(dut.outstanding), 32'd2);
        pulse_reset();
        set_rates(0, 100, 100);
        spur_pct = 100;
        run(2);
        spur_pct = 0;
        #1;
        chk1("restart_req", imem_req, 1'b1);
        chk32("restart_addr", imem_addr, RESET_PC);
        set_rates(100, 100, 100);
        clear_log();
        run(8);
        if (del_pc.size() >= 1) chk32("restart_pc0", del_pc[0], RESET_PC);
        else chk32("restart_count", 32'(del_pc.size()), 32'd1);

        // Randomized traffic
        key = 32'h5A5A_0F0F;
        set_rates(60, 50, 60);
        spur_pct = 5;
        redir_pct = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 3) begin
                redirect_valid = 1'b0;
                pulse_reset();
            end
            step();
        end
        redirect_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
